// File: rtl/exposure_sequencer.sv
`default_nettype none
// ==========================================================================
// exposure_sequencer: exposure registers and exposure/readout state machine.
// Optional macro SHUTTER_DELAY_EN adds a pre-exposure delay (SHD). Rev 1.0
// ==========================================================================
module exposure_sequencer #(
   parameter int         CLK_DIV   = 1000,
   parameter logic [7:0] BASE_ADDR = 8'h10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] reg_addr,
   input  logic [7:0] reg_wdata,
   input  logic       reg_we,
   input  logic       reg_re,
   output logic [7:0] reg_rdata,
   output logic       sensor_expose,
   output logic       readout_start,
   input  logic       readout_done,
   output logic       frame_done
);
   localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_PRE     = 3'd2,
      S_EXPOSE  = 3'd3,
      S_WAIT_RO = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   exp_len, shadow;
   logic [PW-1:0] presc;
   logic          cont, done, err;
   logic [7:0]    frame_cnt;
`ifdef SHUTTER_DELAY_EN
   logic [7:0]    shd, pre_cnt;
`endif
   logic [8:0]    addr_diff;
   logic [2:0]    off;
   logic          in_win, wr, rd, start_wr, abort_wr, tick, err_set, frame_evt;

   // 9-bit difference keeps addresses below BASE_ADDR out of the window
   always_comb begin
      addr_diff = {1'b0, reg_addr} - {1'b0, BASE_ADDR};
      in_win    = addr_diff < 9'd8;
      off       = addr_diff[2:0];
      wr        = reg_we && in_win;
      rd        = reg_re && in_win;
      start_wr  = wr && (off == 3'd4) && reg_wdata[0];
      abort_wr  = wr && (off == 3'd4) && reg_wdata[1];
      tick      = (presc == PRESC_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      frame_evt = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_wr) begin
               if (exp_len == 32'd0) err_set   = 1'b1;
               else                  state_nxt = S_ARM;
            end
         end
         S_ARM: begin
            // EXP may have been cleared between the CONT decision and ARM
            if (exp_len == 32'd0) begin
               err_set   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_EXPOSE;
`ifdef SHUTTER_DELAY_EN
               if (shd != 8'd0) state_nxt = S_PRE;
`endif
            end
         end
`ifdef SHUTTER_DELAY_EN
         S_PRE: begin
            if (tick && (pre_cnt == 8'd1)) state_nxt = S_EXPOSE;
         end
`endif
         S_EXPOSE: begin
            if (tick && (shadow == 32'd1)) state_nxt = S_WAIT_RO;
         end
         S_WAIT_RO: begin
            if (readout_done) begin
               frame_evt = 1'b1;
               state_nxt = (cont && (exp_len != 32'd0)) ? S_ARM : S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort_wr) begin
         state_nxt = S_IDLE;
         err_set   = 1'b0;
         frame_evt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc   <= '0;
         shadow  <= 32'd0;
`ifdef SHUTTER_DELAY_EN
         pre_cnt <= 8'd0;
`endif
      end else begin
         presc <= '0;
         case (state)
            S_ARM: begin
               shadow  <= exp_len;
`ifdef SHUTTER_DELAY_EN
               pre_cnt <= shd;
`endif
            end
`ifdef SHUTTER_DELAY_EN
            S_PRE: begin
               presc <= tick ? '0 : presc + 1'b1;
               if (tick) pre_cnt <= pre_cnt - 8'd1;
            end
`endif
            S_EXPOSE: begin
               presc <= tick ? '0 : presc + 1'b1;
               if (tick) shadow <= shadow - 32'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exp_len       <= 32'd0;
         cont          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         frame_cnt     <= 8'd0;
         reg_rdata     <= 8'd0;
         readout_start <= 1'b0;
         frame_done    <= 1'b0;
`ifdef SHUTTER_DELAY_EN
         shd           <= 8'd0;
`endif
      end else begin
         if (wr) begin
            case (off)
               3'd0: exp_len[7:0]   <= reg_wdata;
               3'd1: exp_len[15:8]  <= reg_wdata;
               3'd2: exp_len[23:16] <= reg_wdata;
               3'd3: exp_len[31:24] <= reg_wdata;
               3'd4: cont           <= reg_wdata[2];
`ifdef SHUTTER_DELAY_EN
               3'd7: shd            <= reg_wdata;
`endif
               default: ;
            endcase
         end
         // a set event in the same cycle as the clearing read wins
         if (err_set)                     err  <= 1'b1;
         else if (rd && (off == 3'd5))    err  <= 1'b0;
         if (frame_evt)                   done <= 1'b1;
         else if (rd && (off == 3'd5))    done <= 1'b0;
         if (frame_evt) frame_cnt <= frame_cnt + 8'd1;
         readout_start <= (state == S_EXPOSE) && (state_nxt == S_WAIT_RO);
         frame_done    <= frame_evt;
         reg_rdata     <= 8'd0;
         if (rd) begin
            case (off)
               3'd0: reg_rdata <= exp_len[7:0];
               3'd1: reg_rdata <= exp_len[15:8];
               3'd2: reg_rdata <= exp_len[23:16];
               3'd3: reg_rdata <= exp_len[31:24];
               3'd4: reg_rdata <= {5'b0, cont, 2'b0};
               3'd5: reg_rdata <= {5'b0, err, done, (state != S_IDLE)};
               3'd6: reg_rdata <= frame_cnt;
`ifdef SHUTTER_DELAY_EN
               3'd7: reg_rdata <= shd;
`endif
               default: reg_rdata <= 8'd0;
            endcase
         end
      end
   end

   assign sensor_expose = (state == S_EXPOSE);

endmodule
`default_nettype wire

// File: tb/tb_exposure_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_exposure_sequencer: directed stimulus, cycle model compare. Rev 1.0
// ==========================================================================
module tb_exposure_sequencer;
   localparam int         CLK_DIV = 4;
   localparam logic [7:0] BASE    = 8'h10;
`ifdef SHUTTER_DELAY_EN
   localparam bit SHD_EN = 1'b1;
`else
   localparam bit SHD_EN = 1'b0;
`endif
   localparam int P_IDLE = 0, P_ARM = 1, P_PRE = 2, P_EXP = 3, P_WAIT = 4;

   logic       clk = 1'b0, rst = 1'b1;
   logic [7:0] reg_addr = 8'd0, reg_wdata = 8'd0;
   logic       reg_we = 1'b0, reg_re = 1'b0, readout_done = 1'b0;
   logic [7:0] reg_rdata;
   logic       sensor_expose, readout_start, frame_done;
   int         total = 0, bad = 0;
   bit         model_on = 1'b0;

   exposure_sequencer #(.CLK_DIV(CLK_DIV), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
      .sensor_expose(sensor_expose), .readout_start(readout_start),
      .readout_done(readout_done), .frame_done(frame_done));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Model: phase plus remaining clock counts for the expose/delay windows
   int          m_phase;
   longint      m_left, m_pre;
   logic [31:0] m_exp;
   logic [7:0]  m_fcnt, m_shd, m_rdata;
   logic        m_cont, m_done, m_err, m_rs, m_fd;

   always @(posedge clk) begin : model
      int off;
      bit wr, rd, start, abort, set_done, set_err;
      logic [7:0] rv;
      off      = int'(reg_addr) - int'(BASE);
      wr       = reg_we && off >= 0 && off <= 7;
      rd       = reg_re && off >= 0 && off <= 7;
      start    = wr && off == 4 && reg_wdata[0];
      abort    = wr && off == 4 && reg_wdata[1];
      set_done = 1'b0;
      set_err  = 1'b0;
      if (rst) begin
         m_phase = P_IDLE; m_left = 0; m_pre = 0; m_exp = 0; m_fcnt = 0; m_shd = 0;
         m_rdata = 0; m_cont = 0; m_done = 0; m_err = 0; m_rs = 0; m_fd = 0;
      end else begin
         rv = 8'd0;
         if (rd) begin
            case (off)
               0, 1, 2, 3: rv = m_exp[8*off +: 8];
               4: rv = {5'b0, m_cont, 2'b0};
               5: rv = {5'b0, m_err, m_done, m_phase != P_IDLE};
               6: rv = m_fcnt;
               7: rv = SHD_EN ? m_shd : 8'd0;
               default: rv = 8'd0;
            endcase
         end
         m_rs = 1'b0;
         m_fd = 1'b0;
         if (abort) m_phase = P_IDLE;
         else begin
            case (m_phase)
               P_IDLE: if (start) begin
                  if (m_exp == 0) set_err = 1'b1;
                  else m_phase = P_ARM;
               end
               P_ARM: if (m_exp == 0) begin
                  set_err = 1'b1;
                  m_phase = P_IDLE;
               end else begin
                  m_left  = longint'(m_exp) * CLK_DIV;
                  m_pre   = longint'(m_shd) * CLK_DIV;
                  m_phase = (m_pre > 0) ? P_PRE : P_EXP;
               end
               P_PRE: begin
                  m_pre--;
                  if (m_pre == 0) m_phase = P_EXP;
               end
               P_EXP: begin
                  m_left--;
                  if (m_left == 0) begin m_phase = P_WAIT; m_rs = 1'b1; end
               end
               P_WAIT: if (readout_done) begin
                  m_fd = 1'b1; set_done = 1'b1; m_fcnt++;
                  m_phase = (m_cont && m_exp != 0) ? P_ARM : P_IDLE;
               end
               default: m_phase = P_IDLE;
            endcase
         end
         if (wr) begin
            if (off <= 3) m_exp[8*off +: 8] = reg_wdata;
            if (off == 4) m_cont = reg_wdata[2];
            if (off == 7 && SHD_EN) m_shd = reg_wdata;
         end
         if (set_err) m_err = 1'b1; else if (rd && off == 5) m_err = 1'b0;
         if (set_done) m_done = 1'b1; else if (rd && off == 5) m_done = 1'b0;
         m_rdata = rv;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("model_expose", sensor_expose, m_phase == P_EXP);
         check("model_ro_start", readout_start, m_rs);
         check("model_frame_done", frame_done, m_fd);
         check("model_rdata", reg_rdata, m_rdata);
      end
   end

   int rs_cnt = 0, fd_cnt = 0, cur_len = 0, last_len = 0;
   always @(posedge clk) begin
      if (readout_start) rs_cnt++;
      if (frame_done) fd_cnt++;
      if (sensor_expose) cur_len++;
      else if (cur_len != 0) begin last_len = cur_len; cur_len = 0; end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] off, input logic [7:0] d);
      @(negedge clk); reg_addr = BASE + off; reg_wdata = d; reg_we = 1'b1;
      @(negedge clk); reg_we = 1'b0;
   endtask

   task automatic rd(input logic [7:0] off, output logic [7:0] d);
      @(negedge clk); reg_addr = BASE + off; reg_re = 1'b1;
      @(negedge clk); reg_re = 1'b0; d = reg_rdata;
   endtask

   task automatic rodone();
      @(negedge clk); readout_done = 1'b1;
      @(negedge clk); readout_done = 1'b0;
   endtask

   // delay counts clks from the write strobe to the first high cycle
   task automatic measure(output int delay, output int len);
      delay = 1;
      while (!sensor_expose && delay < 200) begin @(negedge clk); delay++; end
      len = 0;
      while (sensor_expose && len < 200) begin @(negedge clk); len++; end
   endtask

   initial begin
      #1_000_000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      logic [7:0] d;
      int dly, len, rs0, fd0;
      cyc(2);
      model_on = 1'b1;
      cyc(1);
      rst = 1'b0;
      rd(5, d); check("reset_status", d, 8'h00);
      rd(6, d); check("reset_fcnt", d, 8'h00);
      rd(0, d); check("reset_exp0", d, 8'h00);

      // single shot, EXP=3
      wr(0, 3); wr(1, 0); wr(2, 0); wr(3, 0);
      rs0 = rs_cnt;
      wr(4, 8'h01);
      measure(dly, len);
      check("t1_rise_delay", dly, 2);
      check("t1_expose_len", len, 12);
      cyc(2);
      check("t1_ro_start_cnt", rs_cnt - rs0, 1);
      rd(5, d); check("t1_busy", d, 8'h01);
      fd0 = fd_cnt;
      rodone(); cyc(2);
      check("t1_frame_done", fd_cnt - fd0, 1);
      rd(5, d); check("t1_status_done", d, 8'h02);
      rd(5, d); check("t1_status_clear", d, 8'h00);
      rd(6, d); check("t1_fcnt", d, 8'h01);

      // ABORT and START together: ABORT wins
      wr(4, 8'h03); cyc(3);
      rd(5, d); check("abort_start_status", d, 8'h00);

      // EXP=0 start
      wr(0, 0); wr(4, 8'h01); cyc(3);
      rd(5, d); check("t2_err", d, 8'h04);
      rd(5, d); check("t2_err_clear", d, 8'h00);

      // continuous, 3 frames then abort
      wr(0, 5); wr(4, 8'h05);
      for (int i = 0; i < 3; i++) begin
         measure(dly, len);
         check("t3_len", len, 20);
         rodone();
      end
      rd(6, d); check("t3_fcnt", d, 8'h04);
      check("t3_exposing", sensor_expose, 1'b1);
      wr(4, 8'h02);
      check("t3_abort_drop", sensor_expose, 1'b0);
      rs0 = rs_cnt; fd0 = fd_cnt;
      cyc(30); rodone(); cyc(3);
      check("t3_no_ro_start", rs_cnt - rs0, 0);
      check("t3_no_frame_done", fd_cnt - fd0, 0);
      rd(5, d); check("t3_status", d, 8'h02);

      // EXP rewritten mid-frame only affects the next frame
      wr(0, 3); wr(4, 8'h01); cyc(3);
      wr(0, 2);
      measure(dly, len); cyc(2);
      check("t4_old_len", last_len, 12);
      rodone();
      wr(4, 8'h01);
      measure(dly, len);
      check("t4_new_len", len, 8);
      cyc(2); rodone();

      // reset in the middle of an exposure
      wr(4, 8'h01); cyc(3);
      check("t5_pre_exposing", sensor_expose, 1'b1);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("t5_expose", sensor_expose, 1'b0);
      check("t5_ro_start", readout_start, 1'b0);
      check("t5_frame_done", frame_done, 1'b0);
      check("t5_rdata", reg_rdata, 8'h00);
      rd(0, d); check("t5_exp0", d, 8'h00);
      rd(4, d); check("t5_ctrl", d, 8'h00);
      rd(5, d); check("t5_status", d, 8'h00);
      rd(6, d); check("t5_fcnt", d, 8'h00);
      fd0 = fd_cnt; rodone(); cyc(3);
      check("t5_idle_ro_done", fd_cnt - fd0, 0);

      // window edges and offset 7
      wr(8, 8'h09); wr(8'hF0, 8'h07);
      rd(0, d); check("oow_write", d, 8'h00);
      rd(8, d); check("oow_read_hi", d, 8'h00);
      rd(8'hFF, d); check("oow_read_lo", d, 8'h00);
      wr(7, 8'h02);
      rd(7, d); check("off7", d, SHD_EN ? 8'h02 : 8'h00);

      // EXP=1: delay grows by SHD*CLK_DIV when the shutter delay is built in
      wr(0, 1); wr(4, 8'h01);
      measure(dly, len);
      check("shd_rise_delay", dly, SHD_EN ? 10 : 2);
      check("shd_len", len, 4);
      cyc(2); rodone(); cyc(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
